seg7_anim_ctrl: RTL and testbench



---
 rtl/seg7_anim_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_seg7_anim_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_anim_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_anim_ctrl
//
// Control core for the 7-segment animation designs. Four raw push-buttons are
// synchronised, debounced into one-shot press events and turned into:
//   - the animation index (next / previous, wrapping at both ends),
//   - the frame period register "compare" (slower / faster, saturating),
//   - the frame counter, which produces the digit advance and the tick pulse.
//
// Optional feature macro: SEG7_AUTO_REPEAT_EN
//   defined   : a held button repeats, first after REP_DELAY cycles, then
//               every REP_PERIOD cycles.
//   undefined : exactly one event per press; REP_DELAY / REP_PERIOD only take
//               part in the parameter legality checks.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   btn_in     raw buttons: [0] next anim, [1] prev anim,
//              [2] slower (+CMP_STEP), [3] faster (-CMP_STEP)
//   digit_max  last valid digit of the current animation
//   animation  current animation index
//   digit      current frame / digit
//   compare    current frame period minus one
//   tick       one-cycle pulse in the cycle the digit has just advanced
//   btn_evt    registered one-cycle button events
// -----------------------------------------------------------------------------
module seg7_anim_ctrl #(
    parameter int DEB_VAL    = 20000,
    parameter int RPT_W      = 24,
    parameter int REP_DELAY  = 5000000,
    parameter int REP_PERIOD = 2000000,
    parameter int ANI_W      = 6,
    parameter int ANI_MAX    = 63,
    parameter int DIG_W      = 6,
    parameter int CNT_W      = 25,
    parameter int CMP_RESET  = 10000000,
    parameter int CMP_MIN    = 1000000,
    parameter int CMP_MAX    = 20000000,
    parameter int CMP_STEP   = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       btn_in,
    input  logic [DIG_W-1:0] digit_max,
    output logic [ANI_W-1:0] animation,
    output logic [DIG_W-1:0] digit,
    output logic [CNT_W-1:0] compare,
    output logic             tick,
    output logic [3:0]       btn_evt
);

    // ------------------------------------------------------------------
    // Elaboration-time legality
    // ------------------------------------------------------------------
    if (CMP_MIN > CMP_RESET || CMP_RESET > CMP_MAX ||
        longint'(CMP_MAX) >= (longint'(1) << CNT_W)) begin : g_bad_cmp
        $error("seg7_anim_ctrl: need CMP_MIN <= CMP_RESET <= CMP_MAX < 2**CNT_W");
    end
    if (longint'(ANI_MAX) >= (longint'(1) << ANI_W)) begin : g_bad_ani
        $error("seg7_anim_ctrl: ANI_MAX does not fit in ANI_W bits");
    end
    // DEB_VAL >= 2 because ARM is entered with the count already at 1.
    // REP_PERIOD >= 2 keeps events from landing on consecutive cycles.
    if (DEB_VAL < 2 || REP_DELAY < 1 || REP_PERIOD < 2 ||
        longint'(DEB_VAL)    >= (longint'(1) << RPT_W) ||
        longint'(REP_DELAY)  >= (longint'(1) << RPT_W) ||
        longint'(REP_PERIOD) >= (longint'(1) << RPT_W)) begin : g_bad_rpt
        $error("seg7_anim_ctrl: debounce / repeat timing out of range for RPT_W");
    end

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [RPT_W-1:0] DEB_LAST  = RPT_W'(DEB_VAL - 1);
`ifdef SEG7_AUTO_REPEAT_EN
    localparam logic [RPT_W-1:0] DLY_LAST  = RPT_W'(REP_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_LAST  = RPT_W'(REP_PERIOD - 1);
`endif
    localparam logic [ANI_W-1:0] ANI_LAST  = ANI_W'(ANI_MAX);
    localparam logic [CNT_W-1:0] CMP_RST_V = CNT_W'(CMP_RESET);
    // One guard bit above CNT_W so the step arithmetic can never wrap.
    localparam logic [CNT_W:0]   STEP_X    = (CNT_W+1)'(CMP_STEP);
    localparam logic [CNT_W:0]   MIN_X     = (CNT_W+1)'(CMP_MIN);
    localparam logic [CNT_W:0]   MAX_X     = (CNT_W+1)'(CMP_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HELD = 2'd2,
        ST_RPT  = 2'd3
    } btn_state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0]       sync1_reg;
    logic [3:0]       sync2_reg;
    logic [3:0]       btn_evt_reg;
    logic [3:0]       evt_next;
    logic [ANI_W-1:0] animation_reg;
    logic [ANI_W-1:0] animation_next;
    logic [DIG_W-1:0] digit_reg;
    logic [DIG_W-1:0] digit_adv;
    logic [CNT_W-1:0] compare_reg;
    logic [CNT_W-1:0] compare_next;
    logic [CNT_W-1:0] frame_cnt_reg;
    logic             tick_reg;
    logic             anim_change;
    logic             frame_wrap;
    logic [CNT_W:0]   cmp_up;
    logic [CNT_W:0]   cmp_dn;

    // ------------------------------------------------------------------
    // Per-button debounce / repeat FSM
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            btn_state_t       state_reg;
            btn_state_t       state_next;
            logic [RPT_W-1:0] cnt_reg;
            logic [RPT_W-1:0] cnt_next;
            logic             evt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                evt        = 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        if (sync2_reg[gi]) begin
                            // The cycle that sees the first high sample counts.
                            state_next = ST_ARM;
                            cnt_next   = RPT_W'(1);
                        end
                    end
                    ST_ARM: begin
                        if (!sync2_reg[gi]) begin
                            state_next = ST_IDLE;
                            cnt_next   = '0;
                        end else if (cnt_reg == DEB_LAST) begin
                            state_next = ST_HELD;
                            cnt_next   = '0;
                            evt        = 1'b1;
                        end else begin
                            cnt_next   = cnt_reg + RPT_W'(1);
                        end
                    end
                    ST_HELD: begin
                        if (!sync2_reg[gi]) begin
                            state_next = ST_IDLE;
                            cnt_next   = '0;
`ifdef SEG7_AUTO_REPEAT_EN
                        end else if (cnt_reg == DLY_LAST) begin
                            state_next = ST_RPT;
                            cnt_next   = '0;
                            evt        = 1'b1;
                        end else begin
                            cnt_next   = cnt_reg + RPT_W'(1);
`endif
                        end
                    end
                    ST_RPT: begin
`ifdef SEG7_AUTO_REPEAT_EN
                        if (!sync2_reg[gi]) begin
                            state_next = ST_IDLE;
                            cnt_next   = '0;
                        end else if (cnt_reg == PER_LAST) begin
                            cnt_next   = '0;
                            evt        = 1'b1;
                        end else begin
                            cnt_next   = cnt_reg + RPT_W'(1);
                        end
`else
                        // Unreachable without auto-repeat.
                        state_next = ST_IDLE;
                        cnt_next   = '0;
`endif
                    end
                    default: begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            assign evt_next[gi] = evt;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-value logic for animation, compare and digit
    // ------------------------------------------------------------------
    // Opposite events in the same cycle cancel each other.
    assign anim_change = btn_evt_reg[0] ^ btn_evt_reg[1];
    assign frame_wrap  = (frame_cnt_reg >= compare_reg);
    // A digit_max lowered below the current digit wraps to 0.
    assign digit_adv   = (digit_reg >= digit_max) ? '0 : digit_reg + DIG_W'(1);

    always_comb begin
        animation_next = animation_reg;
        if (btn_evt_reg[0] && !btn_evt_reg[1]) begin
            animation_next = (animation_reg == ANI_LAST) ? '0
                                                         : animation_reg + ANI_W'(1);
        end else if (btn_evt_reg[1] && !btn_evt_reg[0]) begin
            animation_next = (animation_reg == '0) ? ANI_LAST
                                                   : animation_reg - ANI_W'(1);
        end
    end

    always_comb begin
        cmp_up       = {1'b0, compare_reg} + STEP_X;
        cmp_dn       = {1'b0, compare_reg} - STEP_X;
        compare_next = compare_reg;
        if (btn_evt_reg[2] && !btn_evt_reg[3]) begin
            compare_next = (cmp_up > MAX_X) ? MAX_X[CNT_W-1:0] : cmp_up[CNT_W-1:0];
        end else if (btn_evt_reg[3] && !btn_evt_reg[2]) begin
            // A set guard bit means the subtraction borrowed.
            compare_next = (cmp_dn[CNT_W] || cmp_dn < MIN_X) ? MIN_X[CNT_W-1:0]
                                                             : cmp_dn[CNT_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg     <= '0;
            sync2_reg     <= '0;
            btn_evt_reg   <= '0;
            animation_reg <= '0;
            compare_reg   <= CMP_RST_V;
            frame_cnt_reg <= '0;
            digit_reg     <= '0;
            tick_reg      <= 1'b0;
        end else begin
            sync1_reg     <= btn_in;
            sync2_reg     <= sync1_reg;
            btn_evt_reg   <= evt_next;
            animation_reg <= animation_next;
            compare_reg   <= compare_next;
            // An animation change restarts the frame and beats a coincident tick.
            if (anim_change) begin
                frame_cnt_reg <= '0;
                digit_reg     <= '0;
                tick_reg      <= 1'b0;
            end else if (frame_wrap) begin
                // ">=" rather than "==" so a shrinking compare fires at once.
                frame_cnt_reg <= '0;
                digit_reg     <= digit_adv;
                tick_reg      <= 1'b1;
            end else begin
                frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
                tick_reg      <= 1'b0;
            end
        end
    end

    assign animation = animation_reg;
    assign digit     = digit_reg;
    assign compare   = compare_reg;
    assign tick      = tick_reg;
    assign btn_evt   = btn_evt_reg;

endmodule

// File: tb/tb_seg7_anim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_anim_ctrl
//
// Self-checking bench for seg7_anim_ctrl with small timing parameters.
// Directed scenarios check fixed expectations; a randomized phase compares
// every output, every cycle, against a behavioural model that works from
// press run-lengths and plain arithmetic. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg7_anim_ctrl;

    localparam int DEB_VAL    = 4;
    localparam int REP_DELAY  = 10;
    localparam int REP_PERIOD = 3;
    localparam int ANI_MAX    = 3;
    localparam int CMP_RESET  = 8;
    localparam int CMP_MIN    = 4;
    localparam int CMP_MAX    = 12;
    localparam int CMP_STEP   = 4;
    localparam int ANI_W      = 6;
    localparam int DIG_W      = 6;
    localparam int CNT_W      = 25;
    localparam int LAT        = DEB_VAL + 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       btn_in = '0;
    logic [DIG_W-1:0] digit_max = DIG_W'(2);
    logic [ANI_W-1:0] animation;
    logic [DIG_W-1:0] digit;
    logic [CNT_W-1:0] compare;
    logic             tick;
    logic [3:0]       btn_evt;

    int checks   = 0;
    int failures = 0;
    int exp_anim = 0;

    seg7_anim_ctrl #(
        .DEB_VAL(DEB_VAL), .RPT_W(24), .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD),
        .ANI_W(ANI_W), .ANI_MAX(ANI_MAX), .DIG_W(DIG_W), .CNT_W(CNT_W),
        .CMP_RESET(CMP_RESET), .CMP_MIN(CMP_MIN), .CMP_MAX(CMP_MAX), .CMP_STEP(CMP_STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .digit_max(digit_max),
        .animation(animation), .digit(digit), .compare(compare),
        .tick(tick), .btn_evt(btn_evt)
    );

    always #5 clk = ~clk;

    // Event rule in terms of r = number of consecutive high samples the
    // button logic has seen (two samples behind btn_in).
    function automatic bit evt_rule(int r);
`ifdef SEG7_AUTO_REPEAT_EN
        return (r == DEB_VAL) ||
               (r >= DEB_VAL + REP_DELAY && ((r - DEB_VAL - REP_DELAY) % REP_PERIOD) == 0);
`else
        return (r == DEB_VAL);
`endif
    endfunction

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    logic [3:0] m_d0 = '0, m_d1 = '0, m_evt = '0;
    int         m_run [4] = '{default: 0};
    int         m_anim = 0, m_dig = 0, m_cmp = CMP_RESET, m_fc = 0;
    bit         m_tick = 1'b0;

    initial begin : model
        logic [3:0] seen;
        logic [3:0] nev;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_d0 = '0; m_d1 = '0; m_evt = '0;
                for (int i = 0; i < 4; i++) m_run[i] = 0;
                m_anim = 0; m_dig = 0; m_cmp = CMP_RESET; m_fc = 0; m_tick = 1'b0;
            end else begin
                seen = m_d1;
                m_d1 = m_d0;
                m_d0 = btn_in;
                if (m_evt[0] != m_evt[1]) begin
                    m_anim = m_evt[0] ? (m_anim + 1) % (ANI_MAX + 1)
                                      : (m_anim + ANI_MAX) % (ANI_MAX + 1);
                    m_fc = 0; m_dig = 0; m_tick = 1'b0;
                end else if (m_fc >= m_cmp) begin
                    m_fc = 0; m_tick = 1'b1;
                    m_dig = (m_dig >= int'(digit_max)) ? 0 : m_dig + 1;
                end else begin
                    m_fc = m_fc + 1; m_tick = 1'b0;
                end
                if (m_evt[2] && !m_evt[3])
                    m_cmp = (m_cmp + CMP_STEP > CMP_MAX) ? CMP_MAX : m_cmp + CMP_STEP;
                else if (m_evt[3] && !m_evt[2])
                    m_cmp = (m_cmp - CMP_STEP < CMP_MIN) ? CMP_MIN : m_cmp - CMP_STEP;
                for (int i = 0; i < 4; i++) begin
                    m_run[i] = seen[i] ? m_run[i] + 1 : 0;
                    nev[i]   = evt_rule(m_run[i]);
                end
                m_evt = nev;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helper: hold mask until all its events appear, then release.
    // lat = falling edges from drive to event, 0 on timeout.
    // ------------------------------------------------------------------
    task automatic press(input logic [3:0] mask, output int lat);
        lat = 0;
        btn_in = mask;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if ((btn_evt & mask) == mask) begin
                lat = i;
                break;
            end
        end
        btn_in = '0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (animation !== '0) begin failures++; $display("FAIL reset_animation got=%0d want=0", animation); end
        checks++; if (digit !== '0) begin failures++; $display("FAIL reset_digit got=%0d want=0", digit); end
        checks++; if (compare !== CNT_W'(CMP_RESET)) begin failures++; $display("FAIL reset_compare got=%0d want=%0d", compare, CMP_RESET); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%0b want=0", tick); end
        checks++; if (btn_evt !== 4'b0) begin failures++; $display("FAIL reset_btn_evt got=%b want=0000", btn_evt); end
        rst_n = 1'b1;
        @(negedge clk);
        exp_anim = 0;
        $display("test_reset done");
    endtask

    task automatic test_bounce();
        int n_ev = 0, ev_at = 0;
        for (int k = 0; k < 18; k++) begin
            btn_in[0] = (k < 3) || (k >= 4 && k < 12);
            @(negedge clk);
            if (btn_evt[0]) begin
                n_ev++;
                ev_at = k + 1;
            end
        end
        btn_in = '0;
        exp_anim = 1;
        checks++; if (n_ev != 1) begin failures++; $display("FAIL bounce_count got=%0d want=1", n_ev); end
        checks++; if (ev_at != 4 + LAT) begin failures++; $display("FAIL bounce_event_time got=%0d want=%0d", ev_at, 4 + LAT); end
        checks++; if (animation !== ANI_W'(exp_anim)) begin failures++; $display("FAIL bounce_animation got=%0d want=%0d", animation, exp_anim); end
        $display("test_bounce events=%0d at=%0d animation=%0d", n_ev, ev_at, animation);
    endtask

    task automatic test_wrap();
        int sel  [3] = '{1, 1, 0};
        int want [3] = '{0, 3, 0};
        int lat;
        bit seen;
        for (int t = 0; t < 3; t++) begin
            // Start right after digit reaches 2 so it is still 2 at the event.
            seen = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (tick && digit == DIG_W'(2)) begin seen = 1'b1; break; end
            end
            checks++; if (!seen) begin failures++; $display("FAIL wrap_wait_digit2 got=timeout want=digit2"); end
            press(4'(1 << sel[t]), lat);
            checks++; if (lat != LAT) begin failures++; $display("FAIL wrap_latency got=%0d want=%0d", lat, LAT); end
            checks++; if (digit !== DIG_W'(2)) begin failures++; $display("FAIL wrap_pre_digit got=%0d want=2", digit); end
            @(negedge clk);
            exp_anim = want[t];
            checks++; if (animation !== ANI_W'(exp_anim)) begin failures++; $display("FAIL wrap_animation got=%0d want=%0d", animation, exp_anim); end
            checks++; if (digit !== '0) begin failures++; $display("FAIL wrap_digit_restart got=%0d want=0", digit); end
            checks++; if (tick !== 1'b0) begin failures++; $display("FAIL wrap_tick got=%0b want=0", tick); end
            $display("test_wrap btn=%0d animation=%0d digit=%0d", sel[t], animation, digit);
        end
    endtask

    task automatic test_speed();
        int sel  [5] = '{2, 2, 3, 3, 3};
        int want [5] = '{12, 12, 8, 4, 4};
        bit meas [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat, gap;
        bit seen;
        for (int t = 0; t < 5; t++) begin
            press(4'(1 << sel[t]), lat);
            checks++; if (lat != LAT) begin failures++; $display("FAIL speed_latency got=%0d want=%0d", lat, LAT); end
            @(negedge clk);
            checks++; if (compare !== CNT_W'(want[t])) begin failures++; $display("FAIL speed_compare got=%0d want=%0d", compare, want[t]); end
            gap = 0;
            if (meas[t]) begin
                seen = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (tick) begin seen = 1'b1; break; end
                end
                if (seen) begin
                    do begin
                        @(negedge clk);
                        gap++;
                    end while (!tick && gap < 40);
                end
                checks++; if (gap != want[t] + 1) begin failures++; $display("FAIL speed_tick_period got=%0d want=%0d", gap, want[t] + 1); end
            end
            $display("test_speed btn=%0d compare=%0d tick_gap=%0d", sel[t], compare, gap);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_repeat();
        localparam int H = 24;
        int  n_ev = 0, exp_n, r;
        bit  want;
        exp_n = 1;
`ifdef SEG7_AUTO_REPEAT_EN
        if (H >= DEB_VAL + REP_DELAY) exp_n += 1 + (H - DEB_VAL - REP_DELAY) / REP_PERIOD;
`endif
        for (int k = 0; k < H + 10; k++) begin
            btn_in[0] = (k < H);
            @(negedge clk);
            r    = k - 1;
            want = (r >= 1 && r <= H) && evt_rule(r);
            checks++; if (btn_evt[0] !== want) begin failures++; $display("FAIL repeat_event cycle=%0d got=%0b want=%0b", k + 1, btn_evt[0], want); end
            if (btn_evt[0]) n_ev++;
        end
        btn_in = '0;
        exp_anim = (exp_anim + exp_n) % (ANI_MAX + 1);
        checks++; if (n_ev != exp_n) begin failures++; $display("FAIL repeat_count got=%0d want=%0d", n_ev, exp_n); end
        checks++; if (animation !== ANI_W'(exp_anim)) begin failures++; $display("FAIL repeat_animation got=%0d want=%0d", animation, exp_anim); end
        $display("test_repeat events=%0d animation=%0d", n_ev, animation);
    endtask

    task automatic test_simultaneous();
        int lat;
        press(4'b0011, lat);
        checks++; if (lat != LAT) begin failures++; $display("FAIL simul_both_events got=%0d want=%0d", lat, LAT); end
        @(negedge clk);
        checks++; if (animation !== ANI_W'(exp_anim)) begin failures++; $display("FAIL simul_animation got=%0d want=%0d", animation, exp_anim); end
        repeat (3) @(negedge clk);
        $display("test_simultaneous latency=%0d animation=%0d", lat, animation);
    endtask

    task automatic test_reset_mid();
        int first = 0;
        btn_in = 4'b0001;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (animation !== '0) begin failures++; $display("FAIL rstmid_animation got=%0d want=0", animation); end
        checks++; if (digit !== '0) begin failures++; $display("FAIL rstmid_digit got=%0d want=0", digit); end
        checks++; if (compare !== CNT_W'(CMP_RESET)) begin failures++; $display("FAIL rstmid_compare got=%0d want=%0d", compare, CMP_RESET); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL rstmid_tick got=%0b want=0", tick); end
        checks++; if (btn_evt !== 4'b0) begin failures++; $display("FAIL rstmid_btn_evt got=%b want=0000", btn_evt); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (btn_evt[0] && first == 0) first = i;
        end
        btn_in = '0;
        checks++; if (first != LAT) begin failures++; $display("FAIL rstmid_first_event got=%0d want=%0d", first, LAT); end
        repeat (3) @(negedge clk);
        exp_anim = 1;
        checks++; if (animation !== ANI_W'(exp_anim)) begin failures++; $display("FAIL rstmid_animation_after got=%0d want=%0d", animation, exp_anim); end
        $display("test_reset_mid first_event=%0d animation=%0d", first, animation);
    endtask

    task automatic test_digit();
        int lat;
        bit seen;
        digit_max = DIG_W'(2);
        press(4'b0001, lat);
        checks++; if (lat != LAT) begin failures++; $display("FAIL digit_latency got=%0d want=%0d", lat, LAT); end
        @(negedge clk);
        exp_anim = (exp_anim + 1) % (ANI_MAX + 1);
        checks++; if (digit !== '0) begin failures++; $display("FAIL digit_restart got=%0d want=0", digit); end
        for (int k = 0; k < 7; k++) begin
            if (k == 5) digit_max = '0;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (tick) begin seen = 1'b1; break; end
            end
            checks++;
            if (!seen) begin
                failures++; $display("FAIL digit_tick_timeout step=%0d got=none want=tick", k);
            end else if (digit !== DIG_W'((k < 5) ? (k + 1) % 3 : 0)) begin
                failures++; $display("FAIL digit_seq step=%0d got=%0d want=%0d", k, digit, (k < 5) ? (k + 1) % 3 : 0);
            end
            $display("test_digit step=%0d digit_max=%0d digit=%0d", k, digit_max, digit);
        end
        digit_max = DIG_W'(2);
        checks++; if (animation !== ANI_W'(exp_anim)) begin failures++; $display("FAIL digit_animation got=%0d want=%0d", animation, exp_anim); end
    endtask

    task automatic test_random();
        logic [3:0] prev_evt = '0;
        int bad = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            checks++; if (animation !== ANI_W'(m_anim)) begin failures++; bad++; $display("FAIL rand_animation cyc=%0d got=%0d want=%0d", c, animation, m_anim); end
            checks++; if (digit !== DIG_W'(m_dig)) begin failures++; bad++; $display("FAIL rand_digit cyc=%0d got=%0d want=%0d", c, digit, m_dig); end
            checks++; if (compare !== CNT_W'(m_cmp)) begin failures++; bad++; $display("FAIL rand_compare cyc=%0d got=%0d want=%0d", c, compare, m_cmp); end
            checks++; if (tick !== m_tick) begin failures++; bad++; $display("FAIL rand_tick cyc=%0d got=%0b want=%0b", c, tick, m_tick); end
            checks++; if (btn_evt !== m_evt) begin failures++; bad++; $display("FAIL rand_btn_evt cyc=%0d got=%b want=%b", c, btn_evt, m_evt); end
            checks++; if ((btn_evt & prev_evt) !== 4'b0) begin failures++; bad++; $display("FAIL rand_evt_back_to_back cyc=%0d got=%b want=0000", c, btn_evt & prev_evt); end
            prev_evt = btn_evt;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 9) == 0) btn_in[b] = ~btn_in[b];
            if ($urandom_range(0, 49) == 0) digit_max = DIG_W'($urandom_range(0, 4));
        end
        btn_in    = '0;
        digit_max = DIG_W'(2);
        repeat (4) @(negedge clk);
        $display("test_random cycles=600 mismatches=%0d", bad);
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_bounce();
        test_wrap();
        test_speed();
        test_repeat();
        test_simultaneous();
        test_reset_mid();
        test_digit();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
